// File: rtl/edge_detect_top.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect_top (with edge_fifo, edge_gray, edge_sobel)
// Purpose  : Streaming RGB -> grayscale -> 3x3 Sobel magnitude pipeline
//            with show-ahead FIFOs decoupling every stage.
// Revision : 1.0 - initial release
// ============================================================================

module edge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw:0]      r_wr_ptr;
  logic [c_aw:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= i_push_data;
    end
  end
endmodule

module edge_gray #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    i_in_empty,
  input  logic [3*DATA_WIDTH-1:0] i_rgb,
  input  logic                    i_out_full,
  output logic                    o_pop,
  output logic                    o_push,
  output logic [DATA_WIDTH-1:0]   o_gray
);
  localparam int c_sum_w = DATA_WIDTH + 2;
  localparam logic [c_sum_w-1:0] c_three = c_sum_w'(3);

  logic [c_sum_w-1:0] w_sum;

  assign w_sum  = c_sum_w'(i_rgb[3*DATA_WIDTH-1:2*DATA_WIDTH]) +
                  c_sum_w'(i_rgb[2*DATA_WIDTH-1:DATA_WIDTH]) +
                  c_sum_w'(i_rgb[DATA_WIDTH-1:0]);
  assign o_gray = DATA_WIDTH'(w_sum / c_three);
  assign o_pop  = !i_in_empty && !i_out_full;
  assign o_push = o_pop;
endmodule

module edge_sobel #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_in_empty,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  input  logic                  i_out_full,
  output logic                  o_pop,
  output logic                  o_push,
  output logic [DATA_WIDTH-1:0] o_data
);
  localparam int c_col_w = $clog2(IMG_WIDTH);
  localparam int c_row_w = $clog2(IMG_HEIGHT);
  localparam int c_sw    = DATA_WIDTH + 4;
  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(IMG_WIDTH - 1);
  localparam logic [c_row_w-1:0] c_last_row = c_row_w'(IMG_HEIGHT - 1);
  localparam logic [c_sw-1:0]    c_pix_max  = c_sw'((1 << DATA_WIDTH) - 1);

  logic [c_col_w-1:0]    r_in_col;
  logic [c_row_w-1:0]    r_in_row;
  logic [c_col_w-1:0]    r_out_col;
  logic [c_row_w-1:0]    r_out_row;
  logic                  r_flush;
  // Two newest window columns; the third column arrives from the line buffers.
  logic [DATA_WIDTH-1:0] r_win [3][2];
  logic [DATA_WIDTH-1:0] r_lb_near [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_lb_far  [IMG_WIDTH];

  logic [DATA_WIDTH-1:0] w_top;
  logic [DATA_WIDTH-1:0] w_mid;
  logic [DATA_WIDTH-1:0] w_bot;
  logic                  w_primed;
  logic                  w_take;
  logic                  w_emit;
  logic                  w_out_last;
  logic                  w_border;
  logic [c_sw-1:0]       w_left;
  logic [c_sw-1:0]       w_right;
  logic [c_sw-1:0]       w_upper;
  logic [c_sw-1:0]       w_lower;
  logic signed [c_sw-1:0] w_gx;
  logic signed [c_sw-1:0] w_gy;
  logic [c_sw-1:0]       w_abs_x;
  logic [c_sw-1:0]       w_abs_y;
  logic [c_sw-1:0]       w_abs_sum;
  logic [c_sw-1:0]       w_half;
  logic [DATA_WIDTH-1:0] w_sat;

  assign w_top = r_lb_far[r_in_col];
  assign w_mid = r_lb_near[r_in_col];
  assign w_bot = i_in_data;

  // Output index lags input index by one row plus one pixel.
  assign w_primed   = (r_in_row > c_row_w'(1)) ||
                      ((r_in_row == c_row_w'(1)) && (r_in_col != '0));
  assign w_take     = !i_in_empty && !i_out_full && !r_flush;
  assign w_emit     = (w_take && w_primed) || (r_flush && !i_out_full);
  assign w_out_last = (r_out_row == c_last_row) && (r_out_col == c_last_col);
  assign w_border   = (r_out_row == '0) || (r_out_row == c_last_row) ||
                      (r_out_col == '0) || (r_out_col == c_last_col);

  assign w_left  = c_sw'(r_win[0][0]) + (c_sw'(r_win[1][0]) << 1) + c_sw'(r_win[2][0]);
  assign w_right = c_sw'(w_top) + (c_sw'(w_mid) << 1) + c_sw'(w_bot);
  assign w_upper = c_sw'(r_win[0][0]) + (c_sw'(r_win[0][1]) << 1) + c_sw'(w_top);
  assign w_lower = c_sw'(r_win[2][0]) + (c_sw'(r_win[2][1]) << 1) + c_sw'(w_bot);

  assign w_gx      = $signed(w_right) - $signed(w_left);
  assign w_gy      = $signed(w_lower) - $signed(w_upper);
  assign w_abs_x   = w_gx[c_sw-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
  assign w_abs_y   = w_gy[c_sw-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
  assign w_abs_sum = w_abs_x + w_abs_y;
  assign w_half    = w_abs_sum >> 1;
  assign w_sat     = (w_half > c_pix_max) ? '1 : DATA_WIDTH'(w_half);

  assign o_pop  = w_take;
  assign o_push = w_emit;
  assign o_data = (r_flush || w_border) ? '0 : w_sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_col  <= '0;
      r_in_row  <= '0;
      r_out_col <= '0;
      r_out_row <= '0;
      r_flush   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= '0;
        r_win[i][1] <= '0;
      end
    end else begin
      if (w_take) begin
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
        end
        r_win[0][1] <= w_top;
        r_win[1][1] <= w_mid;
        r_win[2][1] <= w_bot;
        if (r_in_col == c_last_col) begin
          r_in_col <= '0;
          if (r_in_row == c_last_row) begin
            r_in_row <= '0;
            r_flush  <= 1'b1;
          end else begin
            r_in_row <= r_in_row + 1'b1;
          end
        end else begin
          r_in_col <= r_in_col + 1'b1;
        end
      end
      if (w_emit) begin
        if (r_out_col == c_last_col) begin
          r_out_col <= '0;
          r_out_row <= (r_out_row == c_last_row) ? '0 : r_out_row + 1'b1;
        end else begin
          r_out_col <= r_out_col + 1'b1;
        end
        // The last output of a frame is always a flush zero, so no take competes here.
        if (w_out_last) begin
          r_flush <= 1'b0;
          for (int i = 0; i < 3; i++) begin
            r_win[i][0] <= '0;
            r_win[i][1] <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_take) begin
      r_lb_near[r_in_col] <= w_bot;
      r_lb_far[r_in_col]  <= w_mid;
    end
  end
endmodule

module edge_detect_top #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_inputs,
  input  logic [DATA_WIDTH-1:0] red_in,
  input  logic [DATA_WIDTH-1:0] green_in,
  input  logic [DATA_WIDTH-1:0] blue_in,
  output logic                  fifo_in_gray_full,
  input  logic                  rd_output,
  output logic                  out_empty,
  output logic [DATA_WIDTH-1:0] data_out
);
  logic [3*DATA_WIDTH-1:0] w_rgb_head;
  logic                    w_rgb_empty;
  logic                    w_rgb_pop;
  logic                    w_gray_push;
  logic [DATA_WIDTH-1:0]   w_gray_val;
  logic                    w_gray_full;
  logic                    w_gray_empty;
  logic [DATA_WIDTH-1:0]   w_gray_head;
  logic                    w_gray_pop;
  logic                    w_sob_push;
  logic [DATA_WIDTH-1:0]   w_sob_val;
  logic                    w_out_full;

  edge_fifo #(.WIDTH(3*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_rgb (
    .clk         (clk),
    .rst         (rst),
    .i_push      (wr_inputs),
    .i_push_data ({red_in, green_in, blue_in}),
    .i_pop       (w_rgb_pop),
    .o_full      (fifo_in_gray_full),
    .o_empty     (w_rgb_empty),
    .o_head      (w_rgb_head)
  );

  edge_gray #(.DATA_WIDTH(DATA_WIDTH)) u_gray (
    .i_in_empty (w_rgb_empty),
    .i_rgb      (w_rgb_head),
    .i_out_full (w_gray_full),
    .o_pop      (w_rgb_pop),
    .o_push     (w_gray_push),
    .o_gray     (w_gray_val)
  );

  edge_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_gray (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_gray_push),
    .i_push_data (w_gray_val),
    .i_pop       (w_gray_pop),
    .o_full      (w_gray_full),
    .o_empty     (w_gray_empty),
    .o_head      (w_gray_head)
  );

  edge_sobel #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_sobel (
    .clk        (clk),
    .rst        (rst),
    .i_in_empty (w_gray_empty),
    .i_in_data  (w_gray_head),
    .i_out_full (w_out_full),
    .o_pop      (w_gray_pop),
    .o_push     (w_sob_push),
    .o_data     (w_sob_val)
  );

  edge_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_out (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_sob_push),
    .i_push_data (w_sob_val),
    .i_pop       (rd_output),
    .o_full      (w_out_full),
    .o_empty     (out_empty),
    .o_head      (data_out)
  );
endmodule

`default_nettype wire

// File: tb/tb_edge_detect_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_detect_top
// Purpose  : Scoreboard bench for edge_detect_top on a reduced 24x16 frame.
// Revision : 1.0 - initial release
// ============================================================================

module tb_edge_detect_top;
  localparam int c_w    = 24;
  localparam int c_h    = 16;
  localparam int c_npix = c_w * c_h;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_inputs = 1'b0;
  logic       rd_output = 1'b0;
  logic [7:0] red_in = '0;
  logic [7:0] green_in = '0;
  logic [7:0] blue_in = '0;
  logic       fifo_in_gray_full;
  logic       out_empty;
  logic [7:0] data_out;

  int         checks = 0;
  int         errors = 0;
  int         out_idx = 0;
  int         drop_tries = 0;
  int         saw_full = 0;
  logic [7:0] exp_q [$];
  int         g [c_h][c_w];

  edge_detect_top #(
    .DATA_WIDTH (8),
    .IMG_WIDTH  (c_w),
    .IMG_HEIGHT (c_h),
    .FIFO_DEPTH (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .wr_inputs         (wr_inputs),
    .red_in            (red_in),
    .green_in          (green_in),
    .blue_in           (blue_in),
    .fifo_in_gray_full (fifo_in_gray_full),
    .rd_output         (rd_output),
    .out_empty         (out_empty),
    .data_out          (data_out)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int mode, input int r, input int c);
    int rr, gg, bb;
    case (mode)
      0: begin
        rr = (c * 13 + r * r * 7) & 255;
        gg = ((r * 29) ^ (c * 5)) & 255;
        bb = (r * c * 3 + 40) & 255;
      end
      1: begin rr = 100; gg = 100; bb = 100; end
      2: begin rr = (c >= c_w / 2) ? 255 : 0; gg = rr; bb = rr; end
      default: begin rr = (r == 10 && c == 10) ? 255 : 0; gg = rr; bb = rr; end
    endcase
    return {rr[7:0], gg[7:0], bb[7:0]};
  endfunction

  function automatic int golden(input int r, input int c);
    int gx, gy, m;
    if (r == 0 || r == c_h - 1 || c == 0 || c == c_w - 1) return 0;
    gx = (g[r-1][c+1] + 2 * g[r][c+1] + g[r+1][c+1]) -
         (g[r-1][c-1] + 2 * g[r][c-1] + g[r+1][c-1]);
    gy = (g[r+1][c-1] + 2 * g[r+1][c] + g[r+1][c+1]) -
         (g[r-1][c-1] + 2 * g[r-1][c] + g[r-1][c+1]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = (gx + gy) >> 1;
    return (m > 255) ? 255 : m;
  endfunction

  task automatic push_expected(input int mode);
    logic [23:0] p;
    int e, dr, dc;
    bit interior;
    for (int r = 0; r < c_h; r++) begin
      for (int c = 0; c < c_w; c++) begin
        p = pix(mode, r, c);
        g[r][c] = (int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) / 3;
      end
    end
    for (int r = 0; r < c_h; r++) begin
      for (int c = 0; c < c_w; c++) begin
        interior = (r > 0 && r < c_h - 1 && c > 0 && c < c_w - 1);
        dr = (r > 10) ? r - 10 : 10 - r;
        dc = (c > 10) ? c - 10 : 10 - c;
        case (mode)
          0: e = golden(r, c);
          1: e = 0;
          2: e = (interior && (c == c_w / 2 - 1 || c == c_w / 2)) ? 255 : 0;
          default: e = (interior && dr <= 1 && dc <= 1 && !(dr == 0 && dc == 0)) ? 255 : 0;
        endcase
        exp_q.push_back(8'(e));
      end
    end
  endtask

  task automatic write_frame(input int mode, input int npix, input bit drop_en);
    int idx = 0;
    int guard = 0;
    logic [23:0] p;
    while (idx < npix && guard < 20000) begin
      if (!fifo_in_gray_full) begin
        p = pix(mode, idx / c_w, idx % c_w);
        {red_in, green_in, blue_in} = p;
        wr_inputs = 1'b1;
        idx++;
      end else begin
        saw_full = 1;
        wr_inputs = drop_en;
        {red_in, green_in, blue_in} = 24'hABCDEF;
        if (drop_en) drop_tries++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    wr_inputs = 1'b0;
    if (idx < npix) check("write_timeout", idx, npix);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !out_empty) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drain_left"}, exp_q.size(), 0);
  endtask

  task automatic run_frame(input int mode, input string name);
    push_expected(mode);
    write_frame(mode, c_npix, 1'b0);
    wait_drain(name);
  endtask

  // Scoreboard monitor: every accepted pop is compared against the queue head.
  initial forever begin
    @(negedge clk);
    if (rst && rd_output && !out_empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d required no output", data_out);
      end else begin
        check($sformatf("pixel%0d", out_idx), int'(data_out), int'(exp_q.pop_front()));
        out_idx++;
      end
    end
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_empty", int'(out_empty), 1);
    check("reset_full", int'(fifo_in_gray_full), 0);
    check("reset_data_out", int'(data_out), 0);
    rst = 1'b1;
    rd_output = 1'b1;
    @(posedge clk);
    #1;

    run_frame(0, "natural");
    run_frame(1, "uniform");
    run_frame(2, "vstep");

    push_expected(0);
    saw_full = 0;
    fork
      write_frame(0, c_npix, 1'b1);
      begin
        rd_output = 1'b0;
        repeat (2000) @(posedge clk);
        #1;
        check("bp_full_seen", saw_full, 1);
        check("bp_drop_tried", int'(drop_tries > 0), 1);
        check("bp_full_now", int'(fifo_in_gray_full), 1);
        check("bp_out_not_empty", int'(out_empty), 0);
        rd_output = 1'b1;
      end
    join
    wait_drain("backpressure");

    run_frame(3, "single");

    rd_output = 1'b0;
    write_frame(0, 100, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_pre_out_empty", int'(out_empty), 0);
    rst = 1'b0;
    #1;
    check("midrst_out_empty", int'(out_empty), 1);
    check("midrst_data_out", int'(data_out), 0);
    check("midrst_full", int'(fifo_in_gray_full), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rd_output = 1'b1;
    run_frame(0, "after_reset");
    check("final_out_empty", int'(out_empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
